image_pixel_fetch: RTL and testbench
====================================

// Module: image_pixel_fetch
// PURPOSE
//  Upstream stage of generate_graphic: turns raster (x,y) from the VGA timing block into image-memory read
//  addresses and returns the fetched 32-bit word. Delays x/y and flags so they align with that word.
//  Address is an incremental raster counter (no multiplier): BASE_ADDR + y*IMG_W + x.
//  Outputs drive generate_graphic directly (x_out/y_out -> x,y; pixel_out -> ReadData).
// PARAMETERS
//  IMG_W      200  image width in pixels (x range 0..IMG_W-1)
//  IMG_H      200  image height in pixels (y range 0..IMG_H-1)
//  ADDR_W     16   memory word-address width; must hold BASE_ADDR+IMG_W*IMG_H-1
//  BASE_ADDR  0    word address of pixel (0,0)
//  MEM_LAT    1    cycles from mem_addr sampled by memory to mem_rdata valid (>=1)
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  x_in         in   10      current raster column from VGA timing
//  y_in         in   10      current raster row from VGA timing
//  active_in    in   1       1 = visible area
//  pixel_en     in   1       1-cycle strobe on first clk a new (x_in,y_in) is presented
//  mem_addr     out  ADDR_W  image-memory read address (registered)
//  mem_rd       out  1       read strobe, 1 cycle per fetched pixel
//  mem_rdata    in   32      memory read data, {8'h0,R,G,B}
//  x_out        out  10      x_in delayed by LAT=MEM_LAT+1 clk
//  y_out        out  10      y_in delayed by LAT
//  active_out   out  1       active_in delayed by LAT
//  in_image_out out  1       delayed in_image AND synced
//  pixel_out    out  32      mem_rdata when in_image_out else 32'h0
//  synced       out  1       0 after reset until first (0,0) pixel_en seen
// BEHAVIOUR
//  - Reset (rst_n=0, async): cnt=BASE_ADDR, mem_addr=BASE_ADDR, mem_rd=0, all *_out=0, synced=0, delay regs=0.
//  - in_image = active_in & (x_in<IMG_W) & (y_in<IMG_H), combinational on inputs.
//  - Frame start: pixel_en & x_in==0 & y_in==0 -> mem_addr<=BASE_ADDR, cnt<=BASE_ADDR+1, mem_rd<=1, synced<=1.
//  - Else pixel_en & in_image -> mem_addr<=cnt, cnt<=cnt+1, mem_rd<=1.
//  - Else pixel_en & !in_image -> mem_addr, cnt hold; mem_rd<=0.
//  - pixel_en=0 -> mem_addr, cnt hold; mem_rd<=0 (one read per pixel regardless of hold length).
//  - Frame start overrides increment when both apply; frame start valid even if active_in=0 at (0,0).
//  - cnt wraps modulo 2^ADDR_W; never exceeds BASE_ADDR+IMG_W*IMG_H within a correctly timed frame.
//  - Sideband shift register depth LAT, free-running every clk (not gated by pixel_en):
//    x,y,active,in_image sampled at edge k appear on *_out after edge k+LAT.
//  - Data path: mem_addr updated edge k; memory returns data MEM_LAT edges later; pixel_out registered
//    edge k+LAT -> aligned with x_out/y_out of same pixel.
//  - in_image_out forced 0 while synced=0 (after reset mid-frame, no fetch is trusted until next (0,0)).
//  - pixel_out = in_image_out ? mem_rdata : 32'h0 (registered).
//  - Reset mid-operation: pipeline flushed to zeros immediately; outputs resume after next frame start + LAT.
//  - No backpressure: memory must accept a read every cycle and return data at fixed MEM_LAT.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> all outputs 0 same cycle; synced=0 until (0,0) pixel_en, then 1.
//  2 Raster, MEM_LAT=1, model mem returns addr as data: pixel (5,3) -> mem_addr=605, pixel_out=605
//    with x_out=5,y_out=3 exactly 2 clk after its pixel_en edge.
//  3 Image edge: (199,0)->addr 199, (200,0)->mem_rd=0, pixel_out=0; (0,1)->addr 200.
//  4 Last pixel (199,199) -> addr 39999; (0,200) and beyond -> no reads; next (0,0) -> addr 0.
//  5 pixel_en every 2nd clk (25 MHz pixels): one mem_rd per pixel, mem_addr held across both clks.
//  6 Reset at (50,50), release, run to frame end: in_image_out=0 until (0,0); then addresses match 2.

Source files
------------

// File: rtl/image_pixel_fetch.sv
// image_pixel_fetch
//   Converts the raster position coming from the VGA timing block into
//   image-memory word addresses, issues one read per displayed pixel and
//   re-aligns the raster sideband (x, y, active, in_image) with the word the
//   memory returns, so the downstream graphic stage sees position and colour
//   of the same pixel on the same cycle.
//
//   The address is produced by an incrementing counter instead of computing
//   BASE_ADDR + y*IMG_W + x, which keeps a multiplier out of the pixel path.
//   The counter is re-seeded at every frame start (pixel_en at (0,0)). Until
//   the first frame start after reset, addresses cannot be trusted.
//   in_image_out and pixel_out are held at zero during that time.
//
//   Interface contract:
//     pixel_en is a one-cycle qualifier. It marks the first clock on which a
//     new (x_in, y_in) is presented. Holding the same position for more
//     cycles without pixel_en causes no further reads.
//     mem_rd is a one-cycle read request with no ready/stall. The memory must
//     accept a request on any cycle and return the word exactly MEM_LAT
//     clocks after it samples mem_addr.

module image_pixel_fetch #(
    parameter int IMG_W     = 200,
    parameter int IMG_H     = 200,
    parameter int ADDR_W    = 16,
    parameter int BASE_ADDR = 0,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        x_in,
    input  logic [9:0]        y_in,
    input  logic              active_in,
    input  logic              pixel_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [31:0]       mem_rdata,
    output logic [9:0]        x_out,
    output logic [9:0]        y_out,
    output logic              active_out,
    output logic              in_image_out,
    output logic [31:0]       pixel_out,
    output logic              synced
);

    // Sideband delay in clocks: one for the address register plus MEM_LAT
    // for the memory. The output registers add the final stage, which
    // matches the registered pixel_out.
    localparam int LAT = MEM_LAT + 1;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    // The bounds are one bit wider than the raster inputs, so an image
    // dimension of 1024 still compares correctly.
    localparam logic [10:0]       IMG_W_LIM = 11'(IMG_W);
    localparam logic [10:0]       IMG_H_LIM = 11'(IMG_H);

    // ------------------------------------------------------------------
    // Fetch control state
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] cnt_q,      cnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              synced_q,   synced_d;

    // ------------------------------------------------------------------
    // Sideband delay line: index 0 is the newest sample.
    // ------------------------------------------------------------------
    logic [LAT-1:0][9:0] x_pipe_q,        x_pipe_d;
    logic [LAT-1:0][9:0] y_pipe_q,        y_pipe_d;
    logic [LAT-1:0]      active_pipe_q,   active_pipe_d;
    logic [LAT-1:0]      in_image_pipe_q, in_image_pipe_d;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic [9:0]  x_out_q,        x_out_d;
    logic [9:0]  y_out_q,        y_out_d;
    logic        active_out_q,   active_out_d;
    logic        in_image_out_q, in_image_out_d;
    logic [31:0] pixel_out_q,    pixel_out_d;

    // ------------------------------------------------------------------
    // Pixel classification on the raw inputs
    // ------------------------------------------------------------------
    logic in_image;
    logic frame_start;
    logic x_inside;
    logic y_inside;

    // Decide whether the presented position is an image pixel and whether it opens a frame
    always_comb begin
        x_inside    = ({1'b0, x_in} < IMG_W_LIM);
        y_inside    = ({1'b0, y_in} < IMG_H_LIM);
        in_image    = active_in & x_inside & y_inside;
        // Frame start does not depend on active_in. Some timing blocks
        // present (0,0) before asserting the visible-area flag.
        frame_start = pixel_en & (x_in == 10'd0) & (y_in == 10'd0);
    end

    // Address counter and read strobe: frame start reseeds, in-image pixels advance
    always_comb begin
        cnt_d      = cnt_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        synced_d   = synced_q;

        if (frame_start) begin
            // Issue address BASE now, so the next pixel reads BASE+1.
            mem_addr_d = BASE;
            cnt_d      = BASE + ONE;
            mem_rd_d   = 1'b1;
            synced_d   = 1'b1;
        end else if (pixel_en && in_image) begin
            // Wraps modulo 2^ADDR_W. A correctly timed frame never reaches the wrap.
            mem_addr_d = cnt_q;
            cnt_d      = cnt_q + ONE;
            mem_rd_d   = 1'b1;
        end
        // Otherwise the position is outside the image or is a repeat clock
        // of the same pixel. The address holds and no read is issued.
    end

    // Free-running sideband shift: advances every clock regardless of pixel_en
    always_comb begin
        x_pipe_d           = x_pipe_q;
        y_pipe_d           = y_pipe_q;
        active_pipe_d      = active_pipe_q;
        in_image_pipe_d    = in_image_pipe_q;

        x_pipe_d[0]        = x_in;
        y_pipe_d[0]        = y_in;
        active_pipe_d[0]   = active_in;
        in_image_pipe_d[0] = in_image;

        for (int i = 1; i < LAT; i++) begin
            x_pipe_d[i]        = x_pipe_q[i-1];
            y_pipe_d[i]        = y_pipe_q[i-1];
            active_pipe_d[i]   = active_pipe_q[i-1];
            in_image_pipe_d[i] = in_image_pipe_q[i-1];
        end
    end

    // Final output stage: sideband and returned word registered together
    always_comb begin
        x_out_d        = x_pipe_q[LAT-1];
        y_out_d        = y_pipe_q[LAT-1];
        active_out_d   = active_pipe_q[LAT-1];
        // Data fetched before the counter has been seeded by a frame start
        // belongs to an unknown pixel, so it is hidden.
        in_image_out_d = in_image_pipe_q[LAT-1] & synced_q;
        pixel_out_d    = in_image_out_d ? mem_rdata : 32'h0;
    end

    // Fetch control registers: reset to BASE, reads idle, not synced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= BASE;
            mem_addr_q <= BASE;
            mem_rd_q   <= 1'b0;
            synced_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            synced_q   <= synced_d;
        end
    end

    // Sideband delay registers: flushed to zero on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pipe_q        <= '0;
            y_pipe_q        <= '0;
            active_pipe_q   <= '0;
            in_image_pipe_q <= '0;
        end else begin
            x_pipe_q        <= x_pipe_d;
            y_pipe_q        <= y_pipe_d;
            active_pipe_q   <= active_pipe_d;
            in_image_pipe_q <= in_image_pipe_d;
        end
    end

    // Output registers: all zero on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_out_q        <= '0;
            y_out_q        <= '0;
            active_out_q   <= 1'b0;
            in_image_out_q <= 1'b0;
            pixel_out_q    <= '0;
        end else begin
            x_out_q        <= x_out_d;
            y_out_q        <= y_out_d;
            active_out_q   <= active_out_d;
            in_image_out_q <= in_image_out_d;
            pixel_out_q    <= pixel_out_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_rd       = mem_rd_q;
    assign synced       = synced_q;
    assign x_out        = x_out_q;
    assign y_out        = y_out_q;
    assign active_out   = active_out_q;
    assign in_image_out = in_image_out_q;
    assign pixel_out    = pixel_out_q;

endmodule

// File: tb/tb_image_pixel_fetch.sv
// Bench for image_pixel_fetch. The memory model returns the word address as
// data, so pixel_out can be compared directly against y*IMG_W+x.
module tb_image_pixel_fetch;
  localparam int IMG_W     = 200;
  localparam int IMG_H     = 200;
  localparam int ADDR_W    = 16;
  localparam int BASE_ADDR = 0;
  localparam int MEM_LAT   = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        x_in = '0;
  logic [9:0]        y_in = '0;
  logic              active_in = 1'b0;
  logic              pixel_en = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata;
  logic [9:0]        x_out;
  logic [9:0]        y_out;
  logic              active_out;
  logic              in_image_out;
  logic [31:0]       pixel_out;
  logic              synced;

  int total = 0;
  int bad = 0;

  // expected output entry: {active, in_image, x, y, pixel}
  logic [53:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem_pipe [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) mem_pipe[i] = '0;
  always @(posedge clk) begin
    mem_pipe[0] <= 32'(mem_addr);
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = mem_pipe[MEM_LAT-1];

  image_pixel_fetch #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W),
    .BASE_ADDR(BASE_ADDR), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_in(x_in), .y_in(y_in), .active_in(active_in), .pixel_en(pixel_en),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .x_out(x_out), .y_out(y_out), .active_out(active_out),
    .in_image_out(in_image_out), .pixel_out(pixel_out), .synced(synced)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge. It applies the inputs, crosses one posedge and
  // returns at the next negedge, where the outputs are stable.
  task automatic step(input int x, input int y, input logic act, input logic en);
    x_in = 10'(x);
    y_in = 10'(y);
    active_in = act;
    pixel_en = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One pixel per clock. Checks the fetch right away and queues the expected
  // aligned output, which appears two steps later.
  task automatic pix(input int x, input int y, input logic act,
                     input logic exp_rd, input int exp_addr, input logic exp_in);
    logic [53:0] e;
    step(x, y, act, 1'b1);
    check_eq("mem_rd", 32'(mem_rd), 32'(exp_rd));
    check_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
    exp_q.push_back({act, exp_in, 10'(x), 10'(y), exp_in ? 32'(exp_addr) : 32'h0});
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      check_eq("active_out", 32'(active_out), 32'(e[53]));
      check_eq("in_image_out", 32'(in_image_out), 32'(e[52]));
      check_eq("x_out", 32'(x_out), 32'(e[51:42]));
      check_eq("y_out", 32'(y_out), 32'(e[41:32]));
      check_eq("pixel_out", pixel_out, e[31:0]);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
    check_eq({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check_eq({tag, "_x_out"}, 32'(x_out), 32'd0);
    check_eq({tag, "_y_out"}, 32'(y_out), 32'd0);
    check_eq({tag, "_active_out"}, 32'(active_out), 32'd0);
    check_eq({tag, "_in_image_out"}, 32'(in_image_out), 32'd0);
    check_eq({tag, "_pixel_out"}, pixel_out, 32'd0);
    check_eq({tag, "_synced"}, 32'(synced), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset state
    @(negedge clk);
    check_zero_outputs("rst");
    rst_n = 1'b1;

    // Read before any frame start: the read is issued, but its output stays hidden
    step(3, 3, 1'b1, 1'b1);
    check_eq("pre_mem_rd", 32'(mem_rd), 32'd1);
    check_eq("pre_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("pre_synced", 32'(synced), 32'd0);
    step(3, 3, 1'b1, 1'b0);
    check_eq("pre_hold_rd", 32'(mem_rd), 32'd0);
    step(3, 3, 1'b1, 1'b0);
    check_eq("pre_x_out", 32'(x_out), 32'd3);
    check_eq("pre_y_out", 32'(y_out), 32'd3);
    check_eq("pre_active_out", 32'(active_out), 32'd1);
    check_eq("pre_in_image_out", 32'(in_image_out), 32'd0);
    check_eq("pre_pixel_out", pixel_out, 32'd0);

    // Full frame, one pixel per clock, plus columns past the right edge on row 0
    for (int y = 0; y < IMG_H; y++) begin
      for (int x = 0; x < IMG_W; x++) begin
        pix(x, y, 1'b1, 1'b1, y * IMG_W + x, 1'b1);
        if (x == 0 && y == 0) check_eq("synced_after_start", 32'(synced), 32'd1);
      end
      if (y == 0) begin
        pix(IMG_W, 0, 1'b1, 1'b0, IMG_W - 1, 1'b0);
        pix(IMG_W + 1, 0, 1'b1, 1'b0, IMG_W - 1, 1'b0);
      end
    end
    // Rows below the image, and a blanked position inside the image area
    pix(0, IMG_H, 1'b1, 1'b0, IMG_W * IMG_H - 1, 1'b0);
    pix(150, IMG_H + 10, 1'b1, 1'b0, IMG_W * IMG_H - 1, 1'b0);
    pix(7, 7, 1'b0, 1'b0, IMG_W * IMG_H - 1, 1'b0);
    // The next frame restarts at BASE
    pix(0, 0, 1'b1, 1'b1, 0, 1'b1);
    exp_q.delete();

    // Half-rate pixels: one read per pixel, and the address holds across both clocks
    for (int x = 1; x <= 4; x++) begin
      step(x, 0, 1'b1, 1'b1);
      check_eq("half_rd_en", 32'(mem_rd), 32'd1);
      check_eq("half_addr_en", 32'(mem_addr), 32'(x));
      if (x > 1) begin
        check_eq("half_x_out_en", 32'(x_out), 32'(x - 1));
        check_eq("half_pix_en", pixel_out, 32'(x - 1));
      end
      step(x, 0, 1'b1, 1'b0);
      check_eq("half_rd_hold", 32'(mem_rd), 32'd0);
      check_eq("half_addr_hold", 32'(mem_addr), 32'(x));
      if (x > 1) begin
        check_eq("half_x_out_hold", 32'(x_out), 32'(x - 1));
        check_eq("half_pix_hold", pixel_out, 32'(x - 1));
      end
    end

    // Mid-frame reset at (50,50): the pipeline clears at once
    step(50, 50, 1'b1, 1'b1);
    check_eq("pre_reset_addr", 32'(mem_addr), 32'd5);
    check_eq("pre_reset_x_out", 32'(x_out), 32'd4);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;

    // Not yet synced: reads restart from BASE and the outputs stay hidden
    pix(51, 50, 1'b1, 1'b1, 0, 1'b0);
    pix(52, 50, 1'b1, 1'b1, 1, 1'b0);
    pix(53, 50, 1'b1, 1'b1, 2, 1'b0);
    pix(0, IMG_H, 1'b1, 1'b0, 2, 1'b0);
    check_eq("unsynced", 32'(synced), 32'd0);
    // A frame start with active_in low still reseeds and syncs
    pix(0, 0, 1'b0, 1'b1, 0, 1'b0);
    check_eq("resynced", 32'(synced), 32'd1);
    for (int y = 0; y <= 3; y++) begin
      for (int x = (y == 0) ? 1 : 0; x <= ((y == 3) ? 7 : IMG_W - 1); x++) begin
        pix(x, y, 1'b1, 1'b1, y * IMG_W + x, 1'b1);
      end
    end
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
